// File: rtl/antares_load_store_unit_pkg.sv
// Antares load/store unit shared definitions.
// State encodings, byte-enable constants and request bundle.
package antares_load_store_unit_pkg;

    localparam logic [1:0] LSU_IDLE = 2'd0;
    localparam logic [1:0] LSU_BUSY = 2'd1;
    localparam logic [1:0] LSU_DONE = 2'd2;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_BYTE = 4'b1000;

    typedef struct packed {
        logic       load;
        logic       byte_op;
        logic       half;
        logic       sign;
        logic [1:0] off;
    } lsu_req_t;

    function automatic logic lsu_misaligned(
        input logic [1:0] off,
        input logic       byte_op,
        input logic       half
    );
        logic word;
        word = ~byte_op & ~half;
        return (word & (|off)) | (half & off[0]);
    endfunction

endpackage

// File: rtl/antares_load_aligner.sv
// Antares load aligner: big-endian lane select and extension.
// Offset 0 selects bits [31:24].
module antares_load_aligner
    import antares_load_store_unit_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  offset_i,
    input  logic        byte_i,
    input  logic        half_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed byte and halfword lanes.
    always_comb begin
        byte_lane = data_i[31:24];
        unique case (offset_i)
            2'd0: byte_lane = data_i[31:24];
            2'd1: byte_lane = data_i[23:16];
            2'd2: byte_lane = data_i[15:8];
            2'd3: byte_lane = data_i[7:0];
        endcase
        half_lane = offset_i[1] ? data_i[15:0] : data_i[31:16];
    end

    // Extend the selected lane to 32 bits.
    always_comb begin
        data_o = data_i;
        unique case (1'b1)
            byte_i:
                data_o = {{24{sign_i & byte_lane[7]}}, byte_lane};
            half_i:
                data_o = {{16{sign_i & half_lane[15]}}, half_lane};
            default:
                data_o = data_i;
        endcase
    end

endmodule

// File: rtl/antares_load_store_unit.sv
// Antares load/store unit: data-port handshake, stall,
// load alignment and address/bus exception flags.
module antares_load_store_unit
    import antares_load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_store_data,
    input  logic        mem_mem_read,
    input  logic        mem_mem_write,
    input  logic        mem_byte,
    input  logic        mem_halfword,
    input  logic        mem_sign_extend,
    input  logic        mem_stall,
    input  logic        mem_flush,
    output logic [31:0] mem_read_data,
    output logic        mem_request_stall,
    output logic        exc_address_if_load,
    output logic        exc_address_if_store,
    output logic        exc_bus_error,
    output logic [29:0] dport_address,
    output logic [31:0] dport_data_o,
    output logic [3:0]  dport_wr,
    output logic        dport_enable,
    input  logic [31:0] dport_data_i,
    input  logic        dport_ready,
    input  logic        dport_error
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] TO_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]    state_q, state_d;
    logic [29:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wr_q, wr_d;
    logic          en_q, en_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          flush_q, flush_d;
    logic [CW-1:0] cnt_q, cnt_d;
    lsu_req_t      req_q, req_d;

    logic          idle;
    logic          misal;
    logic          start;
    logic          timeout;
    logic          killed;
    logic [3:0]    st_be;
    logic [31:0]   st_data;
    logic [31:0]   aligned;

    assign idle    = (state_q == LSU_IDLE);
    assign misal   = lsu_misaligned(mem_address[1:0], mem_byte, mem_halfword);
    assign start   = (mem_mem_read | mem_mem_write) & ~misal
                   & ~mem_flush & ~mem_stall;
    assign timeout = TO_EN && (cnt_q == TO_LAST);
    assign killed  = flush_q | mem_flush;

    antares_load_aligner u_aligner (
        .data_i   (dport_data_i),
        .offset_i (req_q.off),
        .byte_i   (req_q.byte_op),
        .half_i   (req_q.half),
        .sign_i   (req_q.sign),
        .data_o   (aligned)
    );

    // Store byte enables and lane-replicated write data.
    always_comb begin
        st_be   = BE_WORD;
        st_data = mem_store_data;
        unique case (1'b1)
            mem_byte: begin
                st_be   = BE_HI_BYTE >> mem_address[1:0];
                st_data = {4{mem_store_data[7:0]}};
            end
            mem_halfword: begin
                st_be   = mem_address[1] ? BE_LO_HALF : BE_HI_HALF;
                st_data = {2{mem_store_data[15:0]}};
            end
            default: begin
                st_be   = BE_WORD;
                st_data = mem_store_data;
            end
        endcase
    end

    // Next-state logic for the bus handshake FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        en_d    = en_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        flush_d = flush_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        unique case (state_q)
            LSU_IDLE: begin
                if (start) begin
                    addr_d       = mem_address[31:2];
                    wdata_d      = mem_mem_write ? st_data : '0;
                    wr_d         = mem_mem_write ? st_be : 4'b0000;
                    en_d         = 1'b1;
                    flush_d      = 1'b0;
                    cnt_d        = '0;
                    req_d.load   = mem_mem_read & ~mem_mem_write;
                    req_d.byte_op = mem_byte;
                    req_d.half   = mem_halfword;
                    req_d.sign   = mem_sign_extend;
                    req_d.off    = mem_address[1:0];
                    state_d      = LSU_BUSY;
                end
            end
            LSU_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_flush) begin
                    flush_d = 1'b1;
                end
                if (dport_ready) begin
                    en_d    = 1'b0;
                    rdata_d = req_q.load ? aligned : '0;
                    err_d   = dport_error;
                    state_d = killed ? LSU_IDLE : LSU_DONE;
                end else if (timeout) begin
                    en_d    = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = killed ? LSU_IDLE : LSU_DONE;
                end
            end
            LSU_DONE: begin
                if (!mem_stall) begin
                    state_d = LSU_IDLE;
                end
            end
            default: begin
                en_d    = 1'b0;
                state_d = LSU_IDLE;
            end
        endcase
    end

    // State and bus-port registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LSU_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= '0;
            en_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            flush_q <= 1'b0;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            en_q    <= en_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    assign dport_address        = addr_q;
    assign dport_data_o         = wdata_q;
    assign dport_wr             = wr_q;
    assign dport_enable         = en_q;
    assign mem_request_stall    = idle ? start : (state_q == LSU_BUSY);
    assign mem_read_data        = (state_q == LSU_DONE) ? rdata_q : '0;
    assign exc_bus_error        = (state_q == LSU_DONE) & err_q;
    assign exc_address_if_load  = idle & mem_mem_read & misal;
    assign exc_address_if_store = idle & mem_mem_write & misal;

endmodule

// File: tb/tb_antares_load_store_unit.sv
// Directed bench for antares_load_store_unit.
// Slave handshake driven cycle by cycle from the tasks.
module tb_antares_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_address;
    logic [31:0] mem_store_data;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic        mem_byte;
    logic        mem_halfword;
    logic        mem_sign_extend;
    logic        mem_stall;
    logic        mem_flush;
    logic [31:0] mem_read_data;
    logic        mem_request_stall;
    logic        exc_address_if_load;
    logic        exc_address_if_store;
    logic        exc_bus_error;
    logic [29:0] dport_address;
    logic [31:0] dport_data_o;
    logic [3:0]  dport_wr;
    logic        dport_enable;
    logic [31:0] dport_data_i;
    logic        dport_ready;
    logic        dport_error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    antares_load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .mem_address          (mem_address),
        .mem_store_data       (mem_store_data),
        .mem_mem_read         (mem_mem_read),
        .mem_mem_write        (mem_mem_write),
        .mem_byte             (mem_byte),
        .mem_halfword         (mem_halfword),
        .mem_sign_extend      (mem_sign_extend),
        .mem_stall            (mem_stall),
        .mem_flush            (mem_flush),
        .mem_read_data        (mem_read_data),
        .mem_request_stall    (mem_request_stall),
        .exc_address_if_load  (exc_address_if_load),
        .exc_address_if_store (exc_address_if_store),
        .exc_bus_error        (exc_bus_error),
        .dport_address        (dport_address),
        .dport_data_o         (dport_data_o),
        .dport_wr             (dport_wr),
        .dport_enable         (dport_enable),
        .dport_data_i         (dport_data_i),
        .dport_ready          (dport_ready),
        .dport_error          (dport_error)
    );

    task automatic clear_inputs();
        mem_address     = '0;
        mem_store_data  = '0;
        mem_mem_read    = 1'b0;
        mem_mem_write   = 1'b0;
        mem_byte        = 1'b0;
        mem_halfword    = 1'b0;
        mem_sign_extend = 1'b0;
        mem_stall       = 1'b0;
        mem_flush       = 1'b0;
        dport_data_i    = '0;
        dport_ready     = 1'b0;
        dport_error     = 1'b0;
    endtask

    // Presents one op in IDLE, answers after 'waits' BUSY cycles,
    // and returns with the DUT in DONE and the op withdrawn.
    task automatic run_op(
        input  logic        rd,
        input  logic        wr,
        input  logic [31:0] a,
        input  logic [31:0] sd,
        input  logic        b,
        input  logic        h,
        input  logic        s,
        input  int          waits,
        input  logic [31:0] rdat,
        input  logic        err,
        output logic [29:0] oa,
        output logic [3:0]  owr,
        output logic [31:0] od,
        output int          nbusy
    );
        @(posedge clk); #1;
        mem_address     = a;
        mem_store_data  = sd;
        mem_mem_read    = rd;
        mem_mem_write   = wr;
        mem_byte        = b;
        mem_halfword    = h;
        mem_sign_extend = s;
        #1;
        nbusy = 0;
        oa = '0;
        owr = '0;
        od = '0;
        for (int i = 0; i <= waits; i++) begin
            @(posedge clk); #1;
            if (i == waits) begin
                dport_ready  = 1'b1;
                dport_data_i = rdat;
                dport_error  = err;
            end
            #1;
            if (i == 0) begin
                oa  = dport_address;
                owr = dport_wr;
                od  = dport_data_o;
            end
            if (dport_enable && mem_request_stall) nbusy++;
        end
        @(posedge clk); #1;
        dport_ready   = 1'b0;
        dport_error   = 1'b0;
        mem_mem_read  = 1'b0;
        mem_mem_write = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        #12;
        checks++; if (dport_enable !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", dport_enable); end
        checks++; if (dport_wr !== 4'b0) begin errors++; $display("FAIL reset_wr got %b exp 0000", dport_wr); end
        checks++; if (dport_address !== 30'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", dport_address); end
        checks++; if (dport_data_o !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", dport_data_o); end
        checks++; if (mem_read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", mem_read_data); end
        checks++; if (mem_request_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", mem_request_stall); end
        checks++; if (exc_bus_error !== 1'b0) begin errors++; $display("FAIL reset_buserr got %b exp 0", exc_bus_error); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_lw();
        logic [29:0] oa; logic [3:0] owr; logic [31:0] od; int nb;
        run_op(1, 0, 32'h1000, 0, 0, 0, 0, 2, 32'hDEADBEEF, 0, oa, owr, od, nb);
        checks++; if (oa !== 30'h400) begin errors++; $display("FAIL lw_addr got %h exp 400", oa); end
        checks++; if (owr !== 4'b0000) begin errors++; $display("FAIL lw_wr got %b exp 0000", owr); end
        checks++; if (nb !== 3) begin errors++; $display("FAIL lw_stall_cycles got %0d exp 3", nb); end
        checks++; if (mem_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", mem_read_data); end
        checks++; if (mem_request_stall !== 1'b0) begin errors++; $display("FAIL lw_done_stall got %b exp 0", mem_request_stall); end
        checks++; if (dport_enable !== 1'b0) begin errors++; $display("FAIL lw_done_en got %b exp 0", dport_enable); end
        checks++; if (exc_bus_error !== 1'b0) begin errors++; $display("FAIL lw_buserr got %b exp 0", exc_bus_error); end
        @(posedge clk); #2;
        checks++; if (mem_read_data !== 32'h0) begin errors++; $display("FAIL lw_idle_data got %h exp 0", mem_read_data); end
    endtask

    task automatic test_loads();
        logic [29:0] oa; logic [3:0] owr; logic [31:0] od; int nb;
        run_op(1, 0, 32'h1003, 0, 1, 0, 1, 0, 32'h123456F0, 0, oa, owr, od, nb);
        checks++; if (mem_read_data !== 32'hFFFFFFF0) begin errors++; $display("FAIL lb_data got %h exp fffffff0", mem_read_data); end
        checks++; if (nb !== 1) begin errors++; $display("FAIL lb_busy got %0d exp 1", nb); end
        run_op(1, 0, 32'h1003, 0, 1, 0, 0, 0, 32'h123456F0, 0, oa, owr, od, nb);
        checks++; if (mem_read_data !== 32'h000000F0) begin errors++; $display("FAIL lbu_data got %h exp 000000f0", mem_read_data); end
        run_op(1, 0, 32'h1002, 0, 0, 1, 1, 0, 32'h123456F0, 0, oa, owr, od, nb);
        checks++; if (mem_read_data !== 32'h000056F0) begin errors++; $display("FAIL lh_data got %h exp 000056f0", mem_read_data); end
        run_op(1, 0, 32'h1000, 0, 0, 1, 1, 1, 32'h80001234, 0, oa, owr, od, nb);
        checks++; if (mem_read_data !== 32'hFFFF8000) begin errors++; $display("FAIL lh_hi_data got %h exp ffff8000", mem_read_data); end
        run_op(1, 0, 32'h1001, 0, 1, 0, 0, 0, 32'h11A23344, 0, oa, owr, od, nb);
        checks++; if (mem_read_data !== 32'h000000A2) begin errors++; $display("FAIL lbu1_data got %h exp 000000a2", mem_read_data); end
    endtask

    task automatic test_stores();
        logic [29:0] oa; logic [3:0] owr; logic [31:0] od; int nb;
        run_op(0, 1, 32'h2001, 32'h000000AB, 1, 0, 0, 0, 32'h55555555, 0, oa, owr, od, nb);
        checks++; if (owr !== 4'b0100) begin errors++; $display("FAIL sb_wr got %b exp 0100", owr); end
        checks++; if (od !== 32'hABABABAB) begin errors++; $display("FAIL sb_wdata got %h exp abababab", od); end
        checks++; if (oa !== 30'h800) begin errors++; $display("FAIL sb_addr got %h exp 800", oa); end
        checks++; if (mem_read_data !== 32'h0) begin errors++; $display("FAIL sb_rdata got %h exp 0", mem_read_data); end
        run_op(0, 1, 32'h2002, 32'h1234CAFE, 0, 1, 0, 0, 32'h0, 0, oa, owr, od, nb);
        checks++; if (owr !== 4'b0011) begin errors++; $display("FAIL sh_wr got %b exp 0011", owr); end
        checks++; if (od !== 32'hCAFECAFE) begin errors++; $display("FAIL sh_wdata got %h exp cafecafe", od); end
        run_op(0, 1, 32'h2000, 32'h11223344, 0, 0, 0, 0, 32'h0, 0, oa, owr, od, nb);
        checks++; if (owr !== 4'b1111) begin errors++; $display("FAIL sw_wr got %b exp 1111", owr); end
        checks++; if (od !== 32'h11223344) begin errors++; $display("FAIL sw_wdata got %h exp 11223344", od); end
    endtask

    task automatic test_misaligned();
        @(posedge clk); #1;
        mem_address = 32'h1002; mem_mem_read = 1'b1;
        #1;
        checks++; if (exc_address_if_load !== 1'b1) begin errors++; $display("FAIL mis_lw_exc got %b exp 1", exc_address_if_load); end
        checks++; if (exc_address_if_store !== 1'b0) begin errors++; $display("FAIL mis_lw_sexc got %b exp 0", exc_address_if_store); end
        checks++; if (mem_request_stall !== 1'b0) begin errors++; $display("FAIL mis_lw_stall got %b exp 0", mem_request_stall); end
        @(posedge clk); #1;
        checks++; if (dport_enable !== 1'b0) begin errors++; $display("FAIL mis_lw_en got %b exp 0", dport_enable); end
        mem_mem_read = 1'b0; mem_mem_write = 1'b1;
        mem_address = 32'h2001; mem_halfword = 1'b1;
        #1;
        checks++; if (exc_address_if_store !== 1'b1) begin errors++; $display("FAIL mis_sh_exc got %b exp 1", exc_address_if_store); end
        checks++; if (exc_address_if_load !== 1'b0) begin errors++; $display("FAIL mis_sh_lexc got %b exp 0", exc_address_if_load); end
        @(posedge clk); #1;
        checks++; if (dport_enable !== 1'b0) begin errors++; $display("FAIL mis_sh_en got %b exp 0", dport_enable); end
        mem_mem_write = 1'b0; mem_halfword = 1'b0;
        mem_address = 32'h1000; mem_mem_read = 1'b1; mem_flush = 1'b1;
        #1;
        checks++; if (mem_request_stall !== 1'b0) begin errors++; $display("FAIL flushed_start_stall got %b exp 0", mem_request_stall); end
        @(posedge clk); #1;
        checks++; if (dport_enable !== 1'b0) begin errors++; $display("FAIL flushed_start_en got %b exp 0", dport_enable); end
        clear_inputs();
    endtask

    task automatic test_timeout();
        logic [29:0] oa; logic [3:0] owr; logic [31:0] od; int nb;
        int  en_cycles;
        bit  dropped;
        @(posedge clk); #1;
        mem_address = 32'h3000; mem_mem_read = 1'b1;
        en_cycles = 0;
        dropped = 1'b0;
        for (int i = 0; i < 10 && !dropped; i++) begin
            @(posedge clk); #1;
            if (dport_enable) begin
                en_cycles++;
            end else begin
                dropped = 1'b1;
                mem_mem_read = 1'b0;
                #1;
                checks++; if (exc_bus_error !== 1'b1) begin errors++; $display("FAIL to_buserr got %b exp 1", exc_bus_error); end
                checks++; if (mem_request_stall !== 1'b0) begin errors++; $display("FAIL to_stall got %b exp 0", mem_request_stall); end
                checks++; if (mem_read_data !== 32'h0) begin errors++; $display("FAIL to_rdata got %h exp 0", mem_read_data); end
            end
        end
        mem_mem_read = 1'b0;
        checks++; if (!dropped) begin errors++; $display("FAIL to_drop got never exp dropped"); end
        checks++; if (en_cycles !== 4) begin errors++; $display("FAIL to_cycles got %0d exp 4", en_cycles); end
        run_op(1, 0, 32'h1000, 0, 0, 0, 0, 1, 32'h12345678, 1, oa, owr, od, nb);
        checks++; if (exc_bus_error !== 1'b1) begin errors++; $display("FAIL slverr_buserr got %b exp 1", exc_bus_error); end
        @(posedge clk); #2;
        checks++; if (exc_bus_error !== 1'b0) begin errors++; $display("FAIL slverr_idle got %b exp 0", exc_bus_error); end
    endtask

    task automatic test_flush();
        @(posedge clk); #1;
        mem_address = 32'h1000; mem_mem_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 1) mem_flush = 1'b1;
            if (i == 2) begin
                mem_flush    = 1'b0;
                mem_mem_read = 1'b0;
                dport_ready  = 1'b1;
                dport_data_i = 32'hA5A5A5A5;
            end
            #1;
            checks++; if (mem_request_stall !== 1'b1) begin errors++; $display("FAIL fl_busy_stall c%0d got %b exp 1", i, mem_request_stall); end
        end
        @(posedge clk); #1;
        dport_ready = 1'b0;
        #1;
        checks++; if (mem_request_stall !== 1'b0) begin errors++; $display("FAIL fl_stall got %b exp 0", mem_request_stall); end
        checks++; if (exc_bus_error !== 1'b0) begin errors++; $display("FAIL fl_buserr got %b exp 0", exc_bus_error); end
        checks++; if (mem_read_data !== 32'h0) begin errors++; $display("FAIL fl_rdata got %h exp 0", mem_read_data); end
        checks++; if (dport_enable !== 1'b0) begin errors++; $display("FAIL fl_en got %b exp 0", dport_enable); end
        @(posedge clk); #2;
        checks++; if (dport_enable !== 1'b0) begin errors++; $display("FAIL fl_idle_en got %b exp 0", dport_enable); end
    endtask

    task automatic test_done_stall();
        logic [29:0] oa; logic [3:0] owr; logic [31:0] od; int nb;
        run_op(1, 0, 32'h1000, 0, 0, 0, 0, 0, 32'hCAFEF00D, 0, oa, owr, od, nb);
        mem_stall = 1'b1;
        mem_mem_read = 1'b1;
        mem_address = 32'h1004;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            checks++; if (mem_read_data !== 32'hCAFEF00D) begin errors++; $display("FAIL hold_data c%0d got %h exp cafef00d", i, mem_read_data); end
            checks++; if (dport_enable !== 1'b0) begin errors++; $display("FAIL hold_en c%0d got %b exp 0", i, dport_enable); end
        end
        mem_stall = 1'b0;
        mem_mem_read = 1'b0;
        @(posedge clk); #2;
        checks++; if (dport_enable !== 1'b0) begin errors++; $display("FAIL hold_exit_en got %b exp 0", dport_enable); end
        checks++; if (mem_read_data !== 32'h0) begin errors++; $display("FAIL hold_exit_data got %h exp 0", mem_read_data); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_flush();
        test_done_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/antares_load_store_unit.md
Name: antares_load_store_unit

Overview:
Memory-stage data-port controller directly downstream of the EX ALU. It consumes the ALU result as the effective address and the store operand, then runs the data-bus handshake. It stalls the pipeline while the bus is busy, aligns and extends load data, and flags address and bus exceptions. Byte order is big-endian: offset 0 maps to bits [31:24].

Parameters:
TIMEOUT_CYCLES, 0, bus-wait limit in cycles; 0 disables the timeout counter.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
mem_address  in  32  effective address (EX ALU result, registered by EX/MEM)
mem_store_data  in  32  store operand
mem_mem_read  in  1  load op
mem_mem_write  in  1  store op
mem_byte  in  1  byte access
mem_halfword  in  1  halfword access (byte=half=0 means word)
mem_sign_extend  in  1  sign-extend loads
mem_stall  in  1  pipeline stall from hazard unit
mem_flush  in  1  kill the op in this stage
mem_read_data  out  32  aligned and extended load result
mem_request_stall  out  1  stall request to hazard unit
exc_address_if_load  out  1  misaligned load
exc_address_if_store  out  1  misaligned store
exc_bus_error  out  1  bus error or timeout on the current op
dport_address  out  30  word address
dport_data_o  out  32  write data
dport_wr  out  4  byte write enables; 0 means read
dport_enable  out  1  request valid
dport_data_i  in  32  read data
dport_ready  in  1  transaction complete
dport_error  in  1  slave error; valid with dport_ready

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, all dport_* outputs 0, read-data register 0, error flag 0, timeout counter 0.
- Misalignment: misaligned = (word & addr[1:0]!=0) | (half & addr[0]).
  - exc_address_if_load = read & misaligned; exc_address_if_store = write & misaligned.
  - Both are combinational, valid in IDLE only, and not masked by flush (the hazard unit masks).
- start = (read|write) & ~misaligned & ~mem_flush & ~mem_stall, evaluated in IDLE.
- States:
  - IDLE:
    - mem_request_stall = start.
    - On start, latch the address, write data and byte enables, set dport_enable=1, go to BUSY.
  - BUSY:
    - mem_request_stall = 1. dport_* held stable.
    - The timeout counter increments.
    - On dport_ready: drop dport_enable; latch aligned read data (0 for stores); error flag = dport_error. Go to DONE, or to IDLE if a flush was seen.
    - On count == TIMEOUT_CYCLES-1 without dport_ready (TIMEOUT_CYCLES>0 only): drop dport_enable, error flag = 1, read data 0, go to DONE.
  - DONE:
    - mem_request_stall = 0. mem_read_data = register. exc_bus_error = error flag.
    - Go to IDLE when ~mem_stall (pipeline advanced); hold in DONE while mem_stall=1.
- Flush while BUSY: the bus transaction is never aborted. A sticky flag causes completion to return to IDLE with the result discarded, so no exception is raised. Stall stays asserted until completion, so no second request overlaps.
- Latency: op presented in cycle N; request in N+1; earliest dport_ready in N+1; result valid and stall low in N+2.
- Store enables and data:
  - SW: wr=1111, data=store_data.
  - SH: wr = addr[1] ? 0011 : 1100, data = {2{sd[15:0]}}.
  - SB: wr = 1000 >> addr[1:0], data = {4{sd[7:0]}}.
- Loads:
  - Byte lane is dport_data_i[31-8*addr[1:0] -: 8].
  - Half lane is addr[1] ? [15:0] : [31:16].
  - Extension is by sign when mem_sign_extend, else zero.
- In IDLE, mem_read_data = 0 and exc_bus_error = 0.
- A reset mid-transaction returns to IDLE immediately and drops dport_enable. The slave must tolerate this.

Decomposition:
- Shared defines file: state encodings (LSU_IDLE, LSU_BUSY, LSU_DONE) and byte-enable constants (BE_WORD, BE_HI_HALF, BE_LO_HALF).
- One natural sub-module, antares_load_aligner: combinational lane select and extension. It is reused by the instruction-fetch path for byte-debug reads.

Test Plan:
- LW at 0x1000, slave ready after 2 wait cycles with 0xDEADBEEF -> dport_address=0x400, wr=0000; stall high 3 cycles; mem_read_data=0xDEADBEEF in DONE.
- LB signed at 0x1003, dport_data_i=0x123456F0 -> mem_read_data=0xFFFFFFF0. LBU at the same address -> 0x000000F0. LH at 0x1002 with signed extension -> 0x000056F0.
- SB at 0x2001 with store_data=0xAB -> wr=0100, dport_data_o=0xABABABAB. SH at 0x2002 -> wr=0011.
- LW at 0x1002 -> exc_address_if_load=1; no dport_enable; stall low. SH at 0x2001 -> exc_address_if_store=1.
- TIMEOUT_CYCLES=4, slave never ready -> dport_enable drops after 4 BUSY cycles; exc_bus_error=1 in DONE. Separately, dport_error with ready -> exc_bus_error=1.
- Flush asserted in the second BUSY cycle, ready in the third -> no DONE, no exc_bus_error, stall low on the next cycle. Also: mem_stall held 3 cycles in DONE -> result is held stable and no new request is issued.
